seg7_disp_sched: RTL and testbench

- Display-source scheduler in front of the 8-digit seven-segment scan driver.
- Shares the one display between NSRC requesters (PC, register probe, memory probe, status, ...).
- Rotates round-robin through valid sources with a fixed dwell time and a blanking gap between pages.
- Accepts a one-shot priority message that pre-empts rotation; drives the driver's 64-bit data and mode inputs.

---
 rtl/seg7_disp_sched.sv | 202 ++++++++++++++++++++
 tb/tb_seg7_disp_sched.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_disp_sched.sv
// Round-robin display-source scheduler feeding the 8-digit seven-segment scan driver.
// Optional macro SEG7_DISP_LIVE_EN: refresh the shown page every cycle instead of snapshotting.
module seg7_disp_sched #(
  parameter int unsigned NSRC     = 4,
  parameter int unsigned SW       = 2,
  parameter int unsigned DWELL    = 50_000_000,
  parameter int unsigned BLANK    = 1000,
  parameter int unsigned PRI_HOLD = 100_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NSRC-1:0]    src_valid,
  input  logic [64*NSRC-1:0] src_data,
  input  logic [NSRC-1:0]    src_mode,
  input  logic               pause,
  input  logic               step,
  input  logic               pri_req,
  input  logic [63:0]        pri_data,
  input  logic               pri_mode,
  output logic               pri_ack,
  output logic [63:0]        disp_data,
  output logic               disp_mode,
  output logic [SW-1:0]      cur_src,
  output logic               page_tick
);

  localparam logic [63:0] BlankData = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {StIdle, StShow, StBlank, StPri} state_e;

  state_e      state_q, state_d;
  logic [SW-1:0] cur_src_q, cur_src_d;
  logic [63:0] disp_data_q, disp_data_d;
  logic        disp_mode_q, disp_mode_d;
  logic        pri_ack_q, pri_ack_d;
  logic        page_tick_q, page_tick_d;
  logic [31:0] dwell_cnt_q, dwell_cnt_d;
  logic [31:0] blank_cnt_q, blank_cnt_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;

  logic [63:0] src_page [NSRC];

  for (genvar g = 0; g < NSRC; g++) begin : g_page
    assign src_page[g] = src_data[64*g +: 64];
  end

  // Source search: lowest valid index from IDLE, or first valid after cur_src (wrapping to itself).
  logic          hit_idle, hit_next;
  logic [SW-1:0] sel_idle, sel_next, scan_idx;

  always_comb begin
    hit_idle = 1'b0;
    sel_idle = '0;
    for (int unsigned k = NSRC; k >= 1; k--) begin
      if (src_valid[SW'(k - 1)]) begin
        hit_idle = 1'b1;
        sel_idle = SW'(k - 1);
      end
    end
    hit_next = 1'b0;
    sel_next = cur_src_q;
    scan_idx = '0;
    for (int unsigned k = NSRC; k >= 1; k--) begin
      scan_idx = SW'((32'(cur_src_q) + k) % NSRC);
      if (src_valid[scan_idx]) begin
        hit_next = 1'b1;
        sel_next = scan_idx;
      end
    end
  end

  logic          go_show, go_blank, go_pri, go_idle;
  logic [SW-1:0] show_idx;

  always_comb begin
    state_d     = state_q;
    cur_src_d   = cur_src_q;
    disp_data_d = disp_data_q;
    disp_mode_d = disp_mode_q;
    pri_ack_d   = 1'b0;
    page_tick_d = 1'b0;
    dwell_cnt_d = dwell_cnt_q;
    blank_cnt_d = blank_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    go_show     = 1'b0;
    go_blank    = 1'b0;
    go_pri      = 1'b0;
    go_idle     = 1'b0;
    show_idx    = cur_src_q;

    unique case (state_q)
      StIdle: begin
        if (pri_req) begin
          go_pri = 1'b1;
        end else if (hit_idle) begin
          go_show  = 1'b1;
          show_idx = sel_idle;
        end
      end
      StShow: begin
        if (pri_req) begin
          go_pri = 1'b1;
        end else if (!src_valid[cur_src_q] || step) begin
          go_blank = 1'b1;
        end else begin
          if (!pause) begin
            if (dwell_cnt_q == DWELL - 1) begin
              go_blank = 1'b1;
            end else begin
              dwell_cnt_d = dwell_cnt_q + 32'd1;
            end
          end
`ifdef SEG7_DISP_LIVE_EN
          disp_data_d = src_page[cur_src_q];
          disp_mode_d = src_mode[cur_src_q];
`endif
        end
      end
      StBlank: begin
        if (pri_req) begin
          go_pri = 1'b1;
        end else if (blank_cnt_q == BLANK - 1) begin
          if (hit_next) begin
            go_show  = 1'b1;
            show_idx = sel_next;
          end else begin
            go_idle = 1'b1;
          end
        end else begin
          blank_cnt_d = blank_cnt_q + 32'd1;
        end
      end
      StPri: begin
        if (hold_cnt_q == PRI_HOLD - 1) begin
          if (pri_req) begin
            go_pri = 1'b1;
          end else begin
            go_blank = 1'b1;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (go_pri) begin
      state_d     = StPri;
      disp_data_d = pri_data;
      disp_mode_d = pri_mode;
      pri_ack_d   = 1'b1;
      hold_cnt_d  = '0;
    end else if (go_show) begin
      state_d     = StShow;
      cur_src_d   = show_idx;
      disp_data_d = src_page[show_idx];
      disp_mode_d = src_mode[show_idx];
      page_tick_d = 1'b1;
      dwell_cnt_d = '0;
    end else if (go_blank) begin
      state_d     = StBlank;
      disp_data_d = BlankData;
      disp_mode_d = 1'b1;
      blank_cnt_d = '0;
    end else if (go_idle) begin
      state_d     = StIdle;
      disp_data_d = BlankData;
      disp_mode_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cur_src_q   <= '0;
      disp_data_q <= BlankData;
      disp_mode_q <= 1'b1;
      pri_ack_q   <= 1'b0;
      page_tick_q <= 1'b0;
      dwell_cnt_q <= '0;
      blank_cnt_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_src_q   <= cur_src_d;
      disp_data_q <= disp_data_d;
      disp_mode_q <= disp_mode_d;
      pri_ack_q   <= pri_ack_d;
      page_tick_q <= page_tick_d;
      dwell_cnt_q <= dwell_cnt_d;
      blank_cnt_q <= blank_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign pri_ack   = pri_ack_q;
  assign disp_data = disp_data_q;
  assign disp_mode = disp_mode_q;
  assign cur_src   = cur_src_q;
  assign page_tick = page_tick_q;

endmodule

// File: tb/tb_seg7_disp_sched.sv
// Scoreboard bench for seg7_disp_sched: stimulus predicts page/priority events, a monitor checks them.
module tb_seg7_disp_sched;

  localparam int unsigned NSRC = 4;
  localparam int unsigned DWELL = 8;
  localparam int unsigned BLANKC = 2;
  localparam int unsigned HOLD = 5;
  localparam logic [63:0] BLK = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src_valid;
  logic [63:0] sd [NSRC];
  logic [255:0] src_data;
  logic [3:0]  src_mode;
  logic        pause, step, pri_req, pri_mode;
  logic [63:0] pri_data;
  logic        pri_ack, disp_mode, page_tick;
  logic [63:0] disp_data;
  logic [1:0]  cur_src;

  assign src_data = {sd[3], sd[2], sd[1], sd[0]};

  seg7_disp_sched #(
    .NSRC(NSRC), .SW(2), .DWELL(DWELL), .BLANK(BLANKC), .PRI_HOLD(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_data(src_data), .src_mode(src_mode),
    .pause(pause), .step(step), .pri_req(pri_req), .pri_data(pri_data), .pri_mode(pri_mode),
    .pri_ack(pri_ack), .disp_data(disp_data), .disp_mode(disp_mode), .cur_src(cur_src),
    .page_tick(page_tick)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          pri;
    int unsigned src;
    logic [63:0] data;
    bit          mode;
    int unsigned at;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input bit ok, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic goto_edge(input int unsigned n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input bit pri, input int unsigned src, input logic [63:0] data,
                      input bit mode, input int unsigned at);
    exp_t e;
    e.pri = pri; e.src = src; e.data = data; e.mode = mode; e.at = at;
    sb.push_back(e);
  endtask

  function automatic int unsigned next_src(input int unsigned cur, input logic [3:0] m);
    for (int unsigned k = 1; k <= NSRC; k++) begin
      if (m[(cur + k) % NSRC]) return (cur + k) % NSRC;
    end
    return cur;
  endfunction

  // Monitor: every page_tick / pri_ack is matched against the oldest predicted event.
  always @(negedge clk) begin
    if (!rst && (page_tick || pri_ack)) begin
      if (page_tick && pri_ack) begin
        check("both_pulses", 1'b0, {62'd0, page_tick, pri_ack}, 64'd1);
      end else if (sb.size() == 0) begin
        check("unexpected_event", 1'b0, {32'd0, cyc}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("event_kind", pri_ack == e.pri, {63'd0, pri_ack}, {63'd0, e.pri});
        check("event_cycle", cyc == e.at, {32'd0, cyc}, {32'd0, e.at});
        check("event_src", 32'(cur_src) == e.src, {62'd0, cur_src}, {32'd0, e.src});
        check("event_data", disp_data == e.data && disp_mode == e.mode, disp_data, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  task automatic chk_blank(input string name);
    check(name, disp_data == BLK && disp_mode == 1'b1, disp_data, BLK);
  endtask

  initial begin
    int unsigned t0, t1, t3, t4, t5, t6, t7, t, tn, cur, nxt, d, p, r;
    logic [3:0]  mask;
    logic [63:0] newd, oldd;

    rst = 1'b1; src_valid = 4'b1111; src_mode = 4'b0000;
    pause = 0; step = 0; pri_req = 0; pri_data = '0; pri_mode = 0;
    for (int i = 0; i < NSRC; i++) sd[i] = 64'h1111_1111_1111_1111 * (i + 1);

    for (int unsigned e = 1; e <= 3; e++) begin
      goto_edge(e);
      @(negedge clk);
      chk_blank("reset_blank");
      check("reset_cur_src", cur_src == 2'd0, {62'd0, cur_src}, 64'd0);
      check("reset_pulses", !page_tick && !pri_ack, {62'd0, page_tick, pri_ack}, 64'd0);
    end
    rst = 1'b0;
    src_valid = 4'b1011;

    // Rotation 0,1,3,0,1 with 10-cycle page period.
    t0 = 4;
    push(0, 0, sd[0], 0, t0);
    push(0, 1, sd[1], 0, t0 + 10);
    push(0, 3, sd[3], 0, t0 + 20);
    push(0, 0, sd[0], 0, t0 + 30);
    t1 = t0 + 40;
    push(0, 1, sd[1], 0, t1);

    // Pause holds src1 for 28 cycles.
    goto_edge(t1);
    pause = 1'b1;
    goto_edge(t1 + 20);
    pause = 1'b0;
    push(0, 3, sd[3], 0, t1 + 30);
    push(0, 0, sd[0], 0, t1 + 40);
    t3 = t1 + 50;
    push(0, 1, sd[1], 0, t3);
    goto_edge(t1 + 27);
    @(negedge clk);
    check("pause_held", disp_data == sd[1], disp_data, sd[1]);
    goto_edge(t1 + 28);
    @(negedge clk);
    chk_blank("pause_end_blank");

    // Step at dwell 3.
    goto_edge(t3 + 3);
    step = 1'b1;
    goto_edge(t3 + 4);
    step = 1'b0;
    @(negedge clk);
    chk_blank("step_blank");
    t4 = t3 + 6;
    push(0, 3, sd[3], 0, t4);
    push(0, 0, sd[0], 0, t4 + 10);
    t5 = t4 + 20;
    push(0, 1, sd[1], 0, t5);

    // Priority pre-emption at dwell 4 of src1; step during PRI is ignored.
    goto_edge(t5 + 4);
    pri_req = 1'b1; pri_data = 64'hDEAD_BEEF_0000_0001; pri_mode = 1'b0;
    push(1, 1, pri_data, 0, t5 + 5);
    t6 = t5 + 12;
    push(0, 3, sd[3], 0, t6);
    goto_edge(t5 + 5);
    pri_req = 1'b0;
    step = 1'b1;
    for (int unsigned k = 6; k <= 9; k++) begin
      goto_edge(t5 + k);
      step = 1'b0;
      @(negedge clk);
      check("pri_hold_data", disp_data == 64'hDEAD_BEEF_0000_0001, disp_data,
            64'hDEAD_BEEF_0000_0001);
    end
    goto_edge(t5 + 10);
    @(negedge clk);
    chk_blank("pri_end_blank");

    // Drop the shown source, then empty everything to reach IDLE.
    goto_edge(t6 + 2);
    src_valid = 4'b0011;
    goto_edge(t6 + 3);
    @(negedge clk);
    chk_blank("drop_blank");
    src_valid = 4'b0000;
    goto_edge(t6 + 8);
    @(negedge clk);
    chk_blank("idle_blank");
    src_valid = 4'b0100;
    t7 = t6 + 9;
    push(0, 2, sd[2], 0, t7);

    // Snapshot versus live view, then self re-show of the only valid source.
    goto_edge(t7 + 2);
    oldd = sd[2];
    newd = {$urandom, $urandom};
    sd[2] = newd;
    push(0, 2, newd, 0, t7 + 10);
    for (int unsigned k = 3; k <= 4; k++) begin
      goto_edge(t7 + k);
      @(negedge clk);
`ifdef SEG7_DISP_LIVE_EN
      check("live_data", disp_data == newd, disp_data, newd);
`else
      check("snapshot_data", disp_data == oldd, disp_data, oldd);
`endif
    end

    // Randomized rotation with pause, step and priority interruptions.
    t = t7 + 10;
    cur = 2;
    goto_edge(t);
    for (int it = 0; it < 40; it++) begin
      mask = 4'($urandom_range(1, 15)) | 4'(1 << cur);
      src_valid = mask;
      for (int i = 0; i < NSRC; i++) sd[i] = {$urandom, $urandom};
      src_mode = 4'($urandom);
      r = $urandom_range(0, 3);
      tn = t + 10;
      if (r == 1) begin
        p = $urandom_range(1, 6);
        pause = 1'b1;
        goto_edge(t + p);
        pause = 1'b0;
        tn = t + 10 + p;
      end else if (r == 2) begin
        d = $urandom_range(0, 7);
        goto_edge(t + d);
        step = 1'b1;
        goto_edge(t + d + 1);
        step = 1'b0;
        tn = t + d + 3;
      end else if (r == 3) begin
        d = $urandom_range(0, 6);
        goto_edge(t + d);
        pri_req = 1'b1; pri_data = {$urandom, $urandom}; pri_mode = 1'($urandom);
        push(1, cur, pri_data, pri_mode, t + d + 1);
        goto_edge(t + d + 1);
        pri_req = 1'b0;
        tn = t + d + 8;
      end
      nxt = next_src(cur, mask);
      push(0, nxt, sd[nxt], src_mode[nxt], tn);
      goto_edge(tn);
      t = tn;
      cur = nxt;
    end

    goto_edge(t + 3);
    @(negedge clk);
    check("scoreboard_drained", sb.size() == 0, 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
